// File: rtl/i2c_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : i2c_master_ctrl
// Description : Byte-level I2C master bus controller. It executes one
//               START / STOP / WRITE / READ command at a time and drives
//               open-drain pull-low enables for SCL and SDA. Each SCL bit
//               period is four quarter phases of QTR_DIV clocks. The slave
//               can stretch the clock.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_master_ctrl #(
  parameter int unsigned QTR_DIV = 67
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [1:0] cmd_i,
  input  logic [7:0] wdata_i,
  input  logic       mack_i,
  output logic [7:0] rdata_o,
  output logic       rx_ack_o,
  output logic       done_o,
  output logic       busy_o,
  output logic       scl_oe_o,
  output logic       sda_oe_o,
  input  logic       scl_i,
  input  logic       sda_i
);

  localparam logic [1:0]  c_cmd_start = 2'd0;
  localparam logic [1:0]  c_cmd_stop  = 2'd1;
  localparam logic [1:0]  c_cmd_write = 2'd2;
  localparam logic [1:0]  c_cmd_read  = 2'd3;
  localparam logic [15:0] c_qtr_last  = 16'(QTR_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_STOP  = 3'd2,
    ST_BIT   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_qcnt;
  logic [1:0]  r_phase;
  logic [3:0]  r_bitcnt;
  logic [1:0]  r_cmd;
  logic [7:0]  r_wdata;
  logic        r_mack;
  logic [7:0]  r_shift;
  logic        r_ack_smp;
  logic [7:0]  r_rdata;
  logic        r_rx_ack;
  logic        r_scl_last;
  logic        r_sda_last;

  logic        w_accept;
  logic        w_active;
  logic        w_stall;
  logic        w_qtr_end;
  logic        w_scl_oe;
  logic        w_sda_oe;
  logic        w_data_bit;

  assign w_accept = cmd_valid_i && (r_state == ST_IDLE);
  assign w_active = (r_state == ST_START) || (r_state == ST_STOP) || (r_state == ST_BIT);

  // The slave may hold SCL low once we release it (bit phase 1, STOP phase 2).
  assign w_stall = (((r_state == ST_BIT) && (r_phase == 2'd1)) ||
                    ((r_state == ST_STOP) && (r_phase == 2'd2))) &&
                   !w_scl_oe && !scl_i;

  assign w_qtr_end = (r_qcnt == c_qtr_last) && !w_stall;

  // State register; reset aborts any command at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode: a command runs until phase 3 of its last quarter ends.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          case (cmd_i)
            c_cmd_start: w_state_nxt = ST_START;
            c_cmd_stop:  w_state_nxt = ST_STOP;
            default:     w_state_nxt = ST_BIT;
          endcase
        end
      end
      ST_START, ST_STOP: begin
        if (w_qtr_end && (r_phase == 2'd3)) w_state_nxt = ST_DONE;
      end
      ST_BIT: begin
        if (w_qtr_end && (r_phase == 2'd3) && (r_bitcnt == 4'd8)) w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Line drive per state and phase; outside a command the last levels persist.
  always_comb begin
    w_scl_oe   = r_scl_last;
    w_sda_oe   = r_sda_last;
    w_data_bit = r_wdata[3'd7 - r_bitcnt[2:0]];
    case (r_state)
      ST_START: begin
        w_scl_oe = r_phase[1];
        w_sda_oe = (r_phase != 2'd0);
      end
      ST_STOP: begin
        w_scl_oe = (r_phase == 2'd0);
        w_sda_oe = ~r_phase[1];
      end
      ST_BIT: begin
        w_scl_oe = (r_phase == 2'd0) || (r_phase == 2'd3);
        if (r_bitcnt == 4'd8) begin
          w_sda_oe = (r_cmd == c_cmd_read) ? ~r_mack : 1'b0;
        end else begin
          w_sda_oe = (r_cmd == c_cmd_write) ? ~w_data_bit : 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Quarter/bit timing, command latching, SDA sampling and result registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_qcnt     <= 16'd0;
      r_phase    <= 2'd0;
      r_bitcnt   <= 4'd0;
      r_cmd      <= c_cmd_start;
      r_wdata    <= 8'h00;
      r_mack     <= 1'b1;
      r_shift    <= 8'h00;
      r_ack_smp  <= 1'b1;
      r_rdata    <= 8'h00;
      r_rx_ack   <= 1'b1;
      r_scl_last <= 1'b0;
      r_sda_last <= 1'b0;
    end else begin
      r_scl_last <= w_scl_oe;
      r_sda_last <= w_sda_oe;
      if (w_accept) begin
        r_cmd    <= cmd_i;
        r_wdata  <= wdata_i;
        r_mack   <= mack_i;
        r_qcnt   <= 16'd0;
        r_phase  <= 2'd0;
        r_bitcnt <= 4'd0;
      end else if (w_active) begin
        if (!w_stall) begin
          if (r_qcnt == c_qtr_last) begin
            r_qcnt  <= 16'd0;
            r_phase <= r_phase + 2'd1;
            if (r_phase == 2'd3) r_bitcnt <= r_bitcnt + 4'd1;
          end else begin
            r_qcnt <= r_qcnt + 16'd1;
          end
        end
        // SDA is sampled at the end of phase 1, while SCL is high.
        if ((r_state == ST_BIT) && (r_phase == 2'd1) && w_qtr_end) begin
          if (r_bitcnt == 4'd8) begin
            if (r_cmd == c_cmd_write) r_ack_smp <= sda_i;
          end else if (r_cmd == c_cmd_read) begin
            r_shift <= {r_shift[6:0], sda_i};
          end
        end
      end
      // Results become visible only when the command completes.
      if ((r_state == ST_BIT) && (w_state_nxt == ST_DONE)) begin
        if (r_cmd == c_cmd_read)  r_rdata  <= r_shift;
        if (r_cmd == c_cmd_write) r_rx_ack <= r_ack_smp;
      end
    end
  end

  assign cmd_ready_o = (r_state == ST_IDLE);
  assign busy_o      = ~cmd_ready_o;
  assign done_o      = (r_state == ST_DONE);
  assign scl_oe_o    = w_scl_oe;
  assign sda_oe_o    = w_sda_oe;
  assign rdata_o     = r_rdata;
  assign rx_ack_o    = r_rx_ack;

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_master_ctrl
// Description : Directed self-checking bench for i2c_master_ctrl with an
//               open-drain bus model and a simple slave (ACK, byte source,
//               clock stretch).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_master_ctrl;

  localparam int c_qtr = 4;

  logic       clk_i;
  logic       rst_ni;
  logic       cmd_valid_i;
  logic       cmd_ready_o;
  logic [1:0] cmd_i;
  logic [7:0] wdata_i;
  logic       mack_i;
  logic [7:0] rdata_o;
  logic       rx_ack_o;
  logic       done_o;
  logic       busy_o;
  logic       scl_oe_o;
  logic       sda_oe_o;
  logic       scl_line;
  logic       sda_line;

  // Slave model controls.
  logic [1:0] slave_mode;   // 0 silent, 1 ACK a write, 2 send slave_byte
  logic [7:0] slave_byte;
  logic       slave_sda_low;
  logic       slave_scl_low;
  logic       stretch_arm;
  logic       stretch_used;
  logic       stretch_trig;
  int         stretch_left;

  // Bus monitor state.
  int          fall_cnt;
  int          fall_base;
  int          rel;
  int          start_cnt;
  int          stop_cnt;
  logic        prev_scl;
  logic        prev_sda;
  logic [15:0] cap_bits;
  logic [15:0] oe_bits;

  int checks;
  int failures;

  i2c_master_ctrl #(.QTR_DIV(c_qtr)) u_dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_i       (cmd_i),
    .wdata_i     (wdata_i),
    .mack_i      (mack_i),
    .rdata_o     (rdata_o),
    .rx_ack_o    (rx_ack_o),
    .done_o      (done_o),
    .busy_o      (busy_o),
    .scl_oe_o    (scl_oe_o),
    .sda_oe_o    (sda_oe_o),
    .scl_i       (scl_line),
    .sda_i       (sda_line)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic slave_pull(input int r, input logic [1:0] mode, input logic [7:0] b);
    logic [7:0] t;
    logic [2:0] idx;
    t = b;
    if (mode == 2'd2 && r >= 0 && r < 8) begin
      idx = 3'(7 - r);
      return ~t[idx];
    end
    if (mode == 2'd1 && r == 8) return 1'b1;
    return 1'b0;
  endfunction

  assign rel           = fall_cnt - fall_base;
  assign slave_sda_low = slave_pull(rel, slave_mode, slave_byte);
  assign stretch_trig  = stretch_arm && !stretch_used && (rel == 3) && !scl_oe_o;
  assign slave_scl_low = stretch_trig || (stretch_left > 0);
  assign scl_line      = ~scl_oe_o & ~slave_scl_low;
  assign sda_line      = ~sda_oe_o & ~slave_sda_low;

  initial begin
    fall_cnt = 0; start_cnt = 0; stop_cnt = 0;
    prev_scl = 1'b1; prev_sda = 1'b1;
    cap_bits = 16'h0; oe_bits = 16'h0;
    stretch_used = 1'b0; stretch_left = 0;
  end

  // Bus monitor: capture SDA on SCL rises, count SCL falls, detect START/STOP.
  always @(negedge clk_i) begin
    if (!prev_scl && scl_line) begin
      cap_bits = {cap_bits[14:0], sda_line};
      oe_bits  = {oe_bits[14:0], sda_oe_o};
    end
    if (prev_scl && !scl_line) fall_cnt = fall_cnt + 1;
    if (prev_scl && scl_line && prev_sda && !sda_line) start_cnt = start_cnt + 1;
    if (prev_scl && scl_line && !prev_sda && sda_line) stop_cnt = stop_cnt + 1;
    if (!stretch_arm) begin
      stretch_used = 1'b0;
    end else if (stretch_trig) begin
      stretch_used = 1'b1;
      stretch_left = 50;
    end else if (stretch_left > 0) begin
      stretch_left = stretch_left - 1;
    end
    prev_scl = scl_line;
    prev_sda = sda_line;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Present a command at a falling edge and hold it across one rising edge.
  task automatic issue(input logic [1:0] c, input logic [7:0] wd, input logic m);
    int n;
    n = 0;
    while (!cmd_ready_o && n < 1000) begin
      @(negedge clk_i);
      n++;
    end
    chk("ready_before_issue", 32'(cmd_ready_o), 32'd1);
    cmd_i       = c;
    wdata_i     = wd;
    mack_i      = m;
    cmd_valid_i = 1'b1;
    fall_base   = fall_cnt;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
  endtask

  // Count busy cycles and done pulses; optionally keep requesting START while busy.
  task automatic wait_done(input bit spam, output int nbusy, output int ndone, output int ninv);
    nbusy = 0; ndone = 0; ninv = 0;
    while (busy_o && nbusy < 2000) begin
      nbusy++;
      if (done_o) ndone++;
      if (busy_o == cmd_ready_o) ninv++;
      if (spam) begin
        cmd_i       = 2'd0;
        cmd_valid_i = 1'b1;
      end
      @(negedge clk_i);
    end
    cmd_valid_i = 1'b0;
  endtask

  int nb, nd, ni, s0, act, n;

  initial begin
    checks = 0; failures = 0;
    rst_ni = 1'b0; cmd_valid_i = 1'b0; cmd_i = 2'd0; wdata_i = 8'h00; mack_i = 1'b0;
    slave_mode = 2'd0; slave_byte = 8'h00; stretch_arm = 1'b0; fall_base = 0;

    #23;
    chk("rst_scl_oe", 32'(scl_oe_o), 32'd0);
    chk("rst_sda_oe", 32'(sda_oe_o), 32'd0);
    chk("rst_ready",  32'(cmd_ready_o), 32'd1);
    chk("rst_busy",   32'(busy_o), 32'd0);
    chk("rst_done",   32'(done_o), 32'd0);
    chk("rst_rdata",  32'(rdata_o), 32'h00);
    chk("rst_rx_ack", 32'(rx_ack_o), 32'd1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    act = 0;
    repeat (4) begin
      @(negedge clk_i);
      act = act | 32'(scl_oe_o) | 32'(sda_oe_o) | 32'(busy_o);
    end
    chk("post_rst_quiet", 32'(act), 32'd0);

    // START
    s0 = start_cnt;
    issue(2'd0, 8'h00, 1'b0);
    wait_done(1'b0, nb, nd, ni);
    chk("start_busy_cycles", 32'(nb), 32'd17);
    chk("start_done_pulses", 32'(nd), 32'd1);
    chk("start_ready_inv",   32'(ni), 32'd0);
    chk("start_condition",   32'(start_cnt - s0), 32'd1);
    chk("start_scl_held",    32'(scl_oe_o), 32'd1);
    chk("start_sda_held",    32'(sda_oe_o), 32'd1);

    // WRITE 0xA5, slave ACKs
    slave_mode = 2'd1;
    issue(2'd2, 8'hA5, 1'b0);
    wait_done(1'b0, nb, nd, ni);
    chk("wr_a5_busy_cycles", 32'(nb), 32'd145);
    chk("wr_a5_done_pulses", 32'(nd), 32'd1);
    chk("wr_a5_bus_bits",    32'(cap_bits[8:0]), 32'h14A);
    chk("wr_a5_rx_ack",      32'(rx_ack_o), 32'd0);
    chk("wr_a5_rdata",       32'(rdata_o), 32'h00);
    chk("wr_a5_scl_held",    32'(scl_oe_o), 32'd1);

    // READ, slave sends 0x3C, master NACKs
    slave_mode = 2'd2; slave_byte = 8'h3C;
    issue(2'd3, 8'h00, 1'b1);
    wait_done(1'b0, nb, nd, ni);
    chk("rd_3c_busy_cycles", 32'(nb), 32'd145);
    chk("rd_3c_rdata",       32'(rdata_o), 32'h3C);
    chk("rd_3c_bus_bits",    32'(cap_bits[8:0]), 32'h079);
    chk("rd_3c_sda_oe_bits", 32'(oe_bits[8:0]), 32'h000);
    chk("rd_3c_rx_ack_kept", 32'(rx_ack_o), 32'd0);

    // WRITE 0x5A, nobody answers
    slave_mode = 2'd0;
    issue(2'd2, 8'h5A, 1'b0);
    wait_done(1'b0, nb, nd, ni);
    chk("wr_nack_rx_ack",    32'(rx_ack_o), 32'd1);
    chk("wr_nack_rdata",     32'(rdata_o), 32'h3C);
    chk("wr_nack_bus_bits",  32'(cap_bits[8:0]), 32'h0B5);

    // WRITE 0xC3 with 50-cycle stretch in bit 3 phase 1
    slave_mode = 2'd1; stretch_arm = 1'b1;
    issue(2'd2, 8'hC3, 1'b0);
    wait_done(1'b0, nb, nd, ni);
    stretch_arm = 1'b0;
    chk("stretch_busy_cycles", 32'(nb), 32'd195);
    chk("stretch_done_pulses", 32'(nd), 32'd1);
    chk("stretch_bus_bits",    32'(cap_bits[8:0]), 32'h186);
    chk("stretch_rx_ack",      32'(rx_ack_o), 32'd0);

    // STOP while hammering cmd_valid_i; nothing may be queued
    slave_mode = 2'd0;
    s0 = stop_cnt;
    issue(2'd1, 8'h00, 1'b0);
    wait_done(1'b1, nb, nd, ni);
    chk("stop_busy_cycles", 32'(nb), 32'd17);
    chk("stop_done_pulses", 32'(nd), 32'd1);
    chk("stop_condition",   32'(stop_cnt - s0), 32'd1);
    chk("stop_scl_rel",     32'(scl_oe_o), 32'd0);
    chk("stop_sda_rel",     32'(sda_oe_o), 32'd0);
    act = 0;
    repeat (5) begin
      @(negedge clk_i);
      act = act | 32'(busy_o) | 32'(scl_oe_o) | 32'(sda_oe_o) | 32'(done_o);
    end
    chk("stop_no_queued_cmd", 32'(act), 32'd0);

    // Reset in WRITE bit 4
    issue(2'd0, 8'h00, 1'b0);
    wait_done(1'b0, nb, nd, ni);
    slave_mode = 2'd1;
    issue(2'd2, 8'h96, 1'b0);
    n = 0;
    while (!(rel == 4 && !scl_oe_o && busy_o) && n < 1000) begin
      @(negedge clk_i);
      n++;
    end
    chk("rst_mid_reached_bit4", 32'(n < 1000), 32'd1);
    #1 rst_ni = 1'b0;
    #1;
    chk("rst_mid_scl_oe", 32'(scl_oe_o), 32'd0);
    chk("rst_mid_sda_oe", 32'(sda_oe_o), 32'd0);
    chk("rst_mid_ready",  32'(cmd_ready_o), 32'd1);
    chk("rst_mid_done",   32'(done_o), 32'd0);
    @(negedge clk_i);
    chk("rst_mid_rdata",  32'(rdata_o), 32'h00);
    chk("rst_mid_rx_ack", 32'(rx_ack_o), 32'd1);
    slave_mode = 2'd0;
    rst_ni = 1'b1;
    act = 0;
    repeat (5) begin
      @(negedge clk_i);
      act = act | 32'(busy_o) | 32'(scl_oe_o) | 32'(sda_oe_o) | 32'(done_o);
    end
    chk("rst_mid_quiet_after", 32'(act), 32'd0);
    s0 = start_cnt;
    issue(2'd0, 8'h00, 1'b0);
    wait_done(1'b0, nb, nd, ni);
    chk("restart_busy_cycles", 32'(nb), 32'd17);
    chk("restart_condition",   32'(start_cnt - s0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
